// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down counter user project: FSM encoding,
// direction and boundary-mode values.
package updown_counter_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_STOPPED = 1'b1
  } state_t;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Free-running 0..PRESCALE-1 divider; tick_o is high for the one cycle the
// divider sits at PRESCALE-1. Cleared by reset (active-low) or clr_i.
module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TOP = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (r_cnt == TOP) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick_o = (r_cnt == TOP);

endmodule

// File: rtl/user_proj_updown_counter.sv
// BITS-wide modulo up/down counter with load, wrap/saturate, one-shot stop,
// terminal-count pulse and sticky overflow. Optional macro: COUNTER_PRESCALE_EN.
module user_proj_updown_counter
  import updown_counter_pkg::*;
#(
  parameter int          BITS      = 8,
  parameter int unsigned MAX_COUNT = 2**BITS - 1,
  parameter int          PRESCALE  = 4
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            en_i,
  input  logic            up_i,
  input  logic            sat_i,
  input  logic            oneshot_i,
  input  logic            load_i,
  input  logic [BITS-1:0] load_val_i,
  input  logic            clr_ovf_i,
  output logic [BITS-1:0] count_o,
  output logic            tc_o,
  output logic            ovf_o,
  output logic            busy_o,
  output logic [BITS-1:0] io_oeb
);

  localparam logic [BITS-1:0] MAX_C = MAX_COUNT[BITS-1:0];

  function automatic logic [BITS-1:0] f_clamp(input logic [BITS-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BITS-1:0] r_count;
  logic [BITS-1:0] w_count_nxt;
  logic            r_tc;
  logic            r_ovf;
  logic [BITS-1:0] r_oeb;
  logic            w_tick;
  logic            w_step;
  logic            w_at_bound;
  logic            w_term;

`ifdef COUNTER_PRESCALE_EN
  logic w_pre_tick;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr_i    (load_i),
    .tick_o   (w_pre_tick)
  );

  assign w_tick = en_i & w_pre_tick;
`else
  assign w_tick = en_i;
`endif

  // A load always pre-empts a tick, so a terminal event needs !load_i.
  assign w_step     = w_tick && !load_i && (r_state == ST_RUN);
  assign w_at_bound = (up_i == DIR_UP) ? (r_count == MAX_C) : (r_count == '0);
  assign w_term     = w_step && w_at_bound;

  always_comb begin
    w_count_nxt = r_count;
    if (load_i) begin
      w_count_nxt = f_clamp(load_val_i);
    end else if (w_step) begin
      if (up_i == DIR_UP) begin
        if (!w_at_bound)              w_count_nxt = r_count + 1'b1;
        else if (sat_i == MODE_WRAP)  w_count_nxt = '0;
        else                          w_count_nxt = MAX_C;
      end else begin
        if (!w_at_bound)              w_count_nxt = r_count - 1'b1;
        else if (sat_i == MODE_WRAP)  w_count_nxt = MAX_C;
        else                          w_count_nxt = '0;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) r_state <= ST_RUN;
    else           r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (w_term && oneshot_i) w_state_nxt = ST_STOPPED;
      ST_STOPPED: if (load_i)              w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o = (r_state == ST_RUN);
  end

  // Datapath registers: count, terminal pulse, sticky overflow, pad enables
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_oeb   <= '1;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_term;
      r_oeb   <= '0;
      if (w_term)         r_ovf <= 1'b1;
      else if (clr_ovf_i) r_ovf <= 1'b0;
    end
  end

  assign count_o = r_count;
  assign tc_o    = r_tc;
  assign ovf_o   = r_ovf;
  assign io_oeb  = r_oeb;

endmodule

// File: tb/tb_user_proj_updown_counter.sv
// Directed self-checking bench for user_proj_updown_counter at BITS=4,
// MAX_COUNT=9, PRESCALE=4.
module tb_user_proj_updown_counter;

  localparam int BITS = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en, up, sat, oneshot, load, clr_ovf;
  logic [BITS-1:0] load_val;
  logic [BITS-1:0] count;
  logic            tc, ovf, busy;
  logic [BITS-1:0] oeb;

  int checks   = 0;
  int failures = 0;

  user_proj_updown_counter #(
    .BITS      (BITS),
    .MAX_COUNT (9),
    .PRESCALE  (4)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .en_i       (en),
    .up_i       (up),
    .sat_i      (sat),
    .oneshot_i  (oneshot),
    .load_i     (load),
    .load_val_i (load_val),
    .clr_ovf_i  (clr_ovf),
    .count_o    (count),
    .tc_o       (tc),
    .ovf_o      (ovf),
    .busy_o     (busy),
    .io_oeb     (oeb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic t,
                         input logic o, input logic b);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".tc"},    32'(tc),    32'(t));
    chk({tag, ".ovf"},   32'(ovf),   32'(o));
    chk({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  initial begin
    rst_n = 1'b0; en = 0; up = 0; sat = 0; oneshot = 0; load = 0; clr_ovf = 0;
    load_val = '0;

    // Reset held for two edges, then released
    step(); step();
    chk_all("rst", 4'd0, 1'b0, 1'b0, 1'b1);
    chk("rst.oeb", 32'(oeb), 32'hF);
    rst_n = 1'b1;
    step();
    chk("rel.oeb", 32'(oeb), 32'h0);
    chk_all("rel", 4'd0, 1'b0, 1'b0, 1'b1);

    // Up, wrap mode: 1..9 then 0 with tc and ovf on the wrap
    en = 1; up = 1; sat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_all($sformatf("upwrap%0d", i), 4'(i % 10), i == 10, i == 10, 1'b1);
    end
    en = 0; clr_ovf = 1;
    step();
    chk_all("clrovf", 4'd0, 1'b0, 1'b0, 1'b1);
    clr_ovf = 0;

    // Down, saturate mode from 2: 1,0,0,0 with tc on the last two
    load = 1; load_val = 4'd2;
    step();
    chk_all("ld2", 4'd2, 1'b0, 1'b0, 1'b1);
    load = 0; en = 1; up = 0; sat = 1;
    step(); chk_all("dsat1", 4'd1, 1'b0, 1'b0, 1'b1);
    step(); chk_all("dsat2", 4'd0, 1'b0, 1'b0, 1'b1);
    step(); chk_all("dsat3", 4'd0, 1'b1, 1'b1, 1'b1);
    step(); chk_all("dsat4", 4'd0, 1'b1, 1'b1, 1'b1);
    en = 0;
    step(); chk_all("dsat_idle", 4'd0, 1'b0, 1'b1, 1'b1);

    // One-shot: load 8, count to 9, wrap stops the FSM
    load = 1; load_val = 4'd8; clr_ovf = 1; sat = 0;
    step(); chk_all("os_ld", 4'd8, 1'b0, 1'b0, 1'b1);
    load = 0; clr_ovf = 0; en = 1; up = 1; oneshot = 1;
    step(); chk_all("os9", 4'd9, 1'b0, 1'b0, 1'b1);
    step(); chk_all("os_term", 4'd0, 1'b1, 1'b1, 1'b0);
    step(); chk_all("os_hold", 4'd0, 1'b0, 1'b1, 1'b0);
    oneshot = 0;
    step(); chk_all("os_hold2", 4'd0, 1'b0, 1'b1, 1'b0);
    load = 1; load_val = 4'd3;
    step(); chk_all("os_reload", 4'd3, 1'b0, 1'b1, 1'b1);

    // Load clamp with tick also high; then clr_ovf loses to a wrap event
    load_val = 4'd15; clr_ovf = 1;
    step(); chk_all("clamp", 4'd9, 1'b0, 1'b0, 1'b1);
    load = 0;
    step(); chk_all("ovf_win", 4'd0, 1'b1, 1'b1, 1'b1);
    clr_ovf = 0; up = 0;
    step(); chk_all("dwrap", 4'd9, 1'b1, 1'b1, 1'b1);
    step(); chk_all("dstep", 4'd8, 1'b0, 1'b1, 1'b1);

    // Counting run after a load; the prescaler divides by 4 when built in
    load = 1; load_val = 4'd0; up = 1;
    step(); chk_all("run_ld", 4'd0, 1'b0, 1'b1, 1'b1);
    load = 0;
    for (int i = 0; i < 12; i++) step();
`ifdef COUNTER_PRESCALE_EN
    chk("run12.count", 32'(count), 32'd3);
`else
    chk("run12.count", 32'(count), 32'd2);
`endif

    // Reset mid-run returns everything to reset values at the next edge
    rst_n = 1'b0;
    step();
    chk_all("mid_rst", 4'd0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst.oeb", 32'(oeb), 32'hF);
    en = 0; rst_n = 1'b1;
    step();
    chk("mid_rel.oeb", 32'(oeb), 32'h0);
    chk_all("mid_rel", 4'd0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/user_proj_updown_counter.md
Name: user_proj_updown_counter

Overview:
Parametrised successor to the 2-bit ripple counter user project. A fully synchronous BITS-wide modulo counter with up/down count, synchronous load, wrap or saturate mode, a one-shot stop state machine, a terminal-count pulse and a sticky overflow flag. It sits in the user area behind the top-level wrapper, which maps its control and count signals onto the user GPIO pads.

Parameters:
BITS, 8, counter width in bits (2..32)
MAX_COUNT, 2**BITS-1, modulo top value; legal range 1 <= MAX_COUNT <= 2**BITS-1
PRESCALE, 4, tick divider ratio used only when COUNTER_PRESCALE_EN is defined; legal range >= 2

Ports:
wb_clk_i  in  1  single clock; all state updates on its rising edge
wb_rst_i  in  1  reset, synchronous, active-low
en_i  in  1  count enable; one count step per enabled cycle
up_i  in  1  direction; 1 = up, 0 = down
sat_i  in  1  boundary mode; 1 = saturate, 0 = wrap
oneshot_i  in  1  1 = stop counting after the first terminal event
load_i  in  1  synchronous load strobe
load_val_i  in  BITS  load value
clr_ovf_i  in  1  clears sticky overflow
count_o  out  BITS  current count (registered)
tc_o  out  1  one-cycle terminal-count pulse (registered)
ovf_o  out  1  sticky overflow flag
busy_o  out  1  1 while FSM is in RUN
io_oeb  out  BITS  pad output enables; all 0 (driving) except during reset, when all 1

Behaviour:
- Reset, when wb_rst_i = 0 at a clock edge: count_o = 0, tc_o = 0, ovf_o = 0, FSM = RUN (busy_o = 1), io_oeb = all 1. The first cycle after release drives io_oeb = all 0.
- tick = en_i, ANDed with the prescaler tick when the optional feature is built in.
- Priority per cycle: reset > load > tick.
- Load:
  - count <= min(load_val_i, MAX_COUNT); values above MAX_COUNT clamp.
  - FSM -> RUN.
  - No tc_o and no ovf_o set, even if tick is also high.
- Tick in RUN, up_i = 1:
  - If count < MAX_COUNT: count + 1.
  - If count == MAX_COUNT: terminal event. Wrap mode sets count to 0; saturate mode holds MAX_COUNT.
- Tick in RUN, up_i = 0:
  - If count > 0: count - 1.
  - If count == 0: terminal event. Wrap mode sets count to MAX_COUNT; saturate mode holds 0.
- Terminal event, effects at the next edge:
  - tc_o = 1 for exactly one cycle.
  - ovf_o = 1.
  - If oneshot_i = 1, FSM RUN -> STOPPED.
- Saturate mode fires a terminal event on every tick that stays at the boundary, so tc_o pulses on each such tick.
- STOPPED state:
  - count frozen; ticks ignored; tc_o = 0.
  - Exits only on load_i (-> RUN) or reset.
  - Deasserting oneshot_i does not exit.
- FSM states: RUN, STOPPED. Transitions:
  - RUN -> STOPPED on terminal event with oneshot_i = 1.
  - STOPPED -> RUN on load_i.
- ovf_o: cleared by clr_ovf_i. If a terminal event and clr_ovf_i occur in the same cycle, the set wins.
- Latency: count_o, tc_o and busy_o all reflect an input one cycle after the edge at which it is sampled. There is no combinational path from inputs to outputs.
- up_i, sat_i and oneshot_i may change on any cycle; each tick uses the values sampled on that cycle.
- Arithmetic is BITS wide with no carry-out. MAX_COUNT is compared as a BITS-wide constant.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined:
  - A free-running prescaler (0..PRESCALE-1) advances every cycle and produces a one-cycle tick when it reaches PRESCALE-1.
  - The counter steps only when en_i and the tick are both high.
  - The prescaler resets to 0 on reset and on load_i.
- Not defined: tick = en_i, no prescaler logic is present, and PRESCALE is ignored.

Decomposition:
- Shared package updown_counter_pkg holds:
  - FSM state encoding: ST_RUN = 1'b0, ST_STOPPED = 1'b1.
  - Direction constants: DIR_UP = 1, DIR_DOWN = 0.
  - Mode constants: MODE_WRAP = 0, MODE_SAT = 1.
- One sub-module, counter_prescaler (parameter PRESCALE; ports wb_clk_i, wb_rst_i, clr_i, tick_o), instantiated only under COUNTER_PRESCALE_EN.

Test Plan (BITS=4, MAX_COUNT=9, prescaler off unless stated):
- Reset: hold wb_rst_i=0 for 2 cycles, then release -> count_o=0, tc_o=0, ovf_o=0, busy_o=1; io_oeb=4'hF during reset, 4'h0 after.
- Up wrap: en=1, up=1, sat=0 for 10 ticks from 0 -> count 1..9 then 0; tc_o high only the cycle count returns to 0; ovf_o=1 thereafter; clr_ovf_i pulse -> ovf_o=0.
- Down saturate: load 2, then en=1, up=0, sat=1 for 4 ticks -> count 1,0,0,0; tc_o pulses on each of the last two ticks.
- One-shot: load 8, up=1, oneshot=1, en=1 -> count 9, then terminal event -> count 0, busy_o=0; further ticks hold 0; load 3 -> busy_o=1, count 3.
- Load clamp and priority: load_val=15 with en=1, up=1 -> count 9, no tc_o; clr_ovf_i in the same cycle as a wrap event -> ovf_o=1.
- Prescaler (COUNTER_PRESCALE_EN, PRESCALE=4): en=1, up=1 for 12 cycles -> count 3. Assert wb_rst_i=0 mid-run -> all outputs return to reset values at the next edge.
